ttc_trigger_tagger: RTL and testbench
=====================================

Name: ttc_trigger_tagger

Overview:
- Sits directly downstream of the TTC Channel B receiver, inside the trigger manager path.
- Maintains the free-running trigger timestamp counter and the trigger number counter, both cleared by the receiver's reset strobes.
- On each TTC trigger (L1A) strobe, captures {trigger number, timestamp, fill type} into a tag and queues it in a small FIFO.
- Tags are presented to the readout logic over a valid/ready interface.

Parameters:
- NUM_WIDTH, 24, trigger number width.
- TS_WIDTH, 44, timestamp counter width in clk cycles.
- FIFO_DEPTH, 16, tag FIFO depth in entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  user interface clock.
- reset  in  1  synchronous, active-high reset.
- trigger  in  1  single-cycle L1A strobe from the TTC decoder.
- fill_type  in  2  current fill type from the Channel B receiver.
- reset_trig_num  in  1  single-cycle strobe; clears the trigger number.
- reset_trig_timestamp  in  1  single-cycle strobe; clears the timestamp.
- tag_valid  out  1  FIFO head is valid.
- tag_ready  in  1  consumer accepts the head entry.
- tag_trig_num  out  NUM_WIDTH  trigger number of the head entry.
- tag_timestamp  out  TS_WIDTH  timestamp of the head entry.
- tag_fill_type  out  2  fill type of the head entry.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: at least one trigger was dropped.
- drop_count  out  16  number of dropped triggers; saturates at 16'hFFFF.

Behaviour:
- Reset (synchronous, active-high), applied on the next clk edge:
  - ts_cnt=0, num_cnt=0, FIFO emptied.
  - tag_valid=0, fifo_count=0, overflow=0, drop_count=0.
  - tag_* data outputs=0.
  - Reset asserted mid-operation discards all queued tags.
- Timestamp counter ts_cnt:
  - Increments by 1 every cycle and wraps modulo 2^TS_WIDTH without any flag.
  - Effective value this cycle: ts_eff = reset_trig_timestamp ? 0 : ts_cnt.
  - Next value: ts_cnt <= ts_eff + 1.
- Trigger number counter num_cnt (count of triggers seen since the last clear):
  - Effective base this cycle: num_base = reset_trig_num ? 0 : num_cnt.
  - On trigger: tag number = num_base + 1, and num_cnt <= num_base + 1.
  - Without trigger: num_cnt <= num_base.
  - The first trigger after any clear is numbered 1.
  - Wraps modulo 2^NUM_WIDTH, so the number after all-ones is 0.
- Simultaneous events:
  - Trigger in the same cycle as reset_trig_num: tag number is 1.
  - Trigger in the same cycle as reset_trig_timestamp: tag timestamp is 0.
  - Both clears with a trigger: tag is {1, 0, fill_type}.
- Fill type: the tag captures the fill_type input as sampled in the trigger cycle.
- FIFO push:
  - A trigger pushes {num, ts, fill_type} if the FIFO is not full, evaluated on the pre-pop occupancy.
  - If full, the trigger is dropped even if a pop happens in the same cycle.
  - On a drop: num_cnt still advances (the consumer sees a numbering gap), overflow <= 1, drop_count increments with saturation.
  - overflow and drop_count clear only on reset.
- FIFO output (show-ahead):
  - tag_valid = (fifo_count != 0); tag_* always reflect the head entry.
  - Pop occurs when tag_valid && tag_ready.
  - tag_* must hold stable while tag_valid=1 and tag_ready=0.
  - tag_ready while empty has no effect.
- Latency: a trigger at edge N into an empty FIFO gives tag_valid=1 with that tag's data after edge N+1 (one cycle).
- Push and pop in the same cycle with the FIFO non-full and non-empty: fifo_count is unchanged and ordering is preserved.
- Back-to-back triggers every cycle are accepted up to FIFO_DEPTH entries.

Decomposition:
- Shared package ttc_pkg:
  - FILL_MUON=2'b01 constant and the other fill-type constants.
  - Default NUM_WIDTH and TS_WIDTH.
  - tag record typedef {trig_num, timestamp, fill_type}.
- One sub-module: ttc_tag_fifo, a synchronous show-ahead FIFO.
  - Parameterised by WIDTH and DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same clk and synchronous reset as the parent.

Test Plan:
- Reset, then triggers at cycles 10 and 15 with tag_ready=1 and fill_type=2'b01 -> tags {1, ts=10 relative to reset release, 01} and {2, 15, 01}, each tag_valid one cycle after its trigger.
- reset_trig_num and reset_trig_timestamp pulsed in the same cycle as a trigger with fill_type=2'b10 -> tag {1, 0, 10}; next trigger 5 cycles later -> {2, 5, 10}.
- tag_ready=0 and 17 triggers with FIFO_DEPTH=16 -> fifo_count=16, overflow=1, drop_count=1; after draining, numbers 1..16 read in order; next trigger is tagged 18.
- FIFO full, trigger and pop in the same cycle -> trigger dropped, fifo_count=15, drop_count increments.
- Force num_cnt to 2^24-1, then one trigger -> tag number 0; timestamp wrap from all-ones -> 0 with no side effects.
- Reset asserted with 5 entries queued and tag_ready toggling -> next cycle tag_valid=0, fifo_count=0, overflow=0; the next trigger is tagged 1.

Source files
------------

// File: rtl/ttc_pkg.sv
// Shared definitions for the TTC trigger tagging path: fill-type codes,
// default counter widths and the tag record.
package ttc_pkg;

    localparam int NUM_WIDTH_DEFAULT = 24;
    localparam int TS_WIDTH_DEFAULT  = 44;

    typedef enum logic [1:0] {
        FILL_NONE     = 2'b00,
        FILL_MUON     = 2'b01,
        FILL_LASER    = 2'b10,
        FILL_PEDESTAL = 2'b11
    } fill_type_e;

    typedef struct packed {
        logic [NUM_WIDTH_DEFAULT-1:0] trig_num;
        logic [TS_WIDTH_DEFAULT-1:0]  timestamp;
        logic [1:0]                   fill_type;
    } tag_t;

    // Drop counter sticks at all-ones rather than wrapping back to a small value.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ttc_trigger_tagger_if.sv
// Valid/ready tag stream from the trigger tagger to the readout logic.
interface ttc_trigger_tagger_if #(
    parameter int NUM_WIDTH = 24,
    parameter int TS_WIDTH  = 44
);

    logic                 tag_valid;
    logic                 tag_ready;
    logic [NUM_WIDTH-1:0] tag_trig_num;
    logic [TS_WIDTH-1:0]  tag_timestamp;
    logic [1:0]           tag_fill_type;

    modport master (
        output tag_valid,
        output tag_trig_num,
        output tag_timestamp,
        output tag_fill_type,
        input  tag_ready
    );

    modport slave (
        input  tag_valid,
        input  tag_trig_num,
        input  tag_timestamp,
        input  tag_fill_type,
        output tag_ready
    );

endinterface

// File: rtl/ttc_tag_fifo.sv
// Synchronous show-ahead FIFO: dout always shows the head entry, and reads
// zero while empty so the tag outputs are clean after reset.
module ttc_tag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
            else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
        end
    end

    // Storage is left unreset; stale contents are never visible because dout is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ttc_trigger_tagger.sv
// Timestamps and numbers each L1A trigger and queues the resulting tag
// for readout; triggers arriving while the queue is full are counted as drops.
module ttc_trigger_tagger
    import ttc_pkg::*;
#(
    parameter int NUM_WIDTH  = NUM_WIDTH_DEFAULT,
    parameter int TS_WIDTH   = TS_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          trigger,
    input  logic [1:0]                    fill_type,
    input  logic                          reset_trig_num,
    input  logic                          reset_trig_timestamp,
    ttc_trigger_tagger_if.master          tag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    typedef struct packed {
        logic [NUM_WIDTH-1:0] trig_num;
        logic [TS_WIDTH-1:0]  timestamp;
        logic [1:0]           fill_type;
    } local_tag_t;

    logic [TS_WIDTH-1:0]  ts_cnt;
    logic [TS_WIDTH-1:0]  ts_eff;
    logic [NUM_WIDTH-1:0] num_cnt;
    logic [NUM_WIDTH-1:0] num_base;
    logic [NUM_WIDTH-1:0] num_next;
    local_tag_t           tag_in;
    local_tag_t           tag_out;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 drop;

    // Clear strobes take effect in their own cycle, so a trigger coinciding
    // with a clear is tagged with the cleared values.
    always_comb begin
        ts_eff   = reset_trig_timestamp ? '0 : ts_cnt;
        num_base = reset_trig_num ? '0 : num_cnt;
        num_next = trigger ? num_base + NUM_WIDTH'(1) : num_base;

        tag_in           = '0;
        tag_in.trig_num  = num_base + NUM_WIDTH'(1);
        tag_in.timestamp = ts_eff;
        tag_in.fill_type = fill_type;
    end

    assign fifo_pop = !fifo_empty && tag.tag_ready;
    assign drop     = trigger && fifo_full;

    // The number still advances on a drop so the consumer sees the gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt     <= '0;
            num_cnt    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            ts_cnt  <= ts_eff + TS_WIDTH'(1);
            num_cnt <= num_next;
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc16(drop_count);
            end
        end
    end

    ttc_tag_fifo #(
        .WIDTH ($bits(local_tag_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (trigger),
        .pop   (fifo_pop),
        .din   (tag_in),
        .dout  (tag_out),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tag.tag_valid     = !fifo_empty;
    assign tag.tag_trig_num  = tag_out.trig_num;
    assign tag.tag_timestamp = tag_out.timestamp;
    assign tag.tag_fill_type = tag_out.fill_type;

endmodule

// File: tb/tb_ttc_trigger_tagger.sv
// Directed bench for ttc_trigger_tagger: a full-size instance for numbering,
// overflow and reset behaviour, and a narrow instance for counter wrap-around.
module tb_ttc_trigger_tagger;

    logic clk;
    logic reset;

    logic       trigger;
    logic [1:0] fill_type;
    logic       reset_trig_num;
    logic       reset_trig_timestamp;
    logic [4:0] fifo_count;
    logic       overflow;
    logic [15:0] drop_count;

    logic       w_trigger;
    logic [1:0] w_fill_type;
    logic       w_reset_trig_num;
    logic       w_reset_trig_timestamp;
    logic [2:0] w_fifo_count;
    logic       w_overflow;
    logic [15:0] w_drop_count;

    int cyc;
    int checks;
    int errors;

    ttc_trigger_tagger_if #(.NUM_WIDTH(24), .TS_WIDTH(44)) tag_bus ();
    ttc_trigger_tagger_if #(.NUM_WIDTH(4),  .TS_WIDTH(6))  w_bus ();

    ttc_trigger_tagger #(
        .NUM_WIDTH  (24),
        .TS_WIDTH   (44),
        .FIFO_DEPTH (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .trigger              (trigger),
        .fill_type            (fill_type),
        .reset_trig_num       (reset_trig_num),
        .reset_trig_timestamp (reset_trig_timestamp),
        .tag                  (tag_bus),
        .fifo_count           (fifo_count),
        .overflow             (overflow),
        .drop_count           (drop_count)
    );

    ttc_trigger_tagger #(
        .NUM_WIDTH  (4),
        .TS_WIDTH   (6),
        .FIFO_DEPTH (4)
    ) dut_w (
        .clk                  (clk),
        .reset                (reset),
        .trigger              (w_trigger),
        .fill_type            (w_fill_type),
        .reset_trig_num       (w_reset_trig_num),
        .reset_trig_timestamp (w_reset_trig_timestamp),
        .tag                  (w_bus),
        .fifo_count           (w_fifo_count),
        .overflow             (w_overflow),
        .drop_count           (w_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic check_output(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        trigger = 1'b0;
        fill_type = 2'b00;
        reset_trig_num = 1'b0;
        reset_trig_timestamp = 1'b0;
        tag_bus.tag_ready = 1'b0;
        w_trigger = 1'b0;
        w_fill_type = 2'b00;
        w_reset_trig_num = 1'b0;
        w_reset_trig_timestamp = 1'b0;
        w_bus.tag_ready = 1'b1;

        $display("[TB] reset and basic tagging");
        do_reset();
        check_output("reset_valid", 64'(tag_bus.tag_valid), 64'd0);
        check_output("reset_count", 64'(fifo_count), 64'd0);
        check_output("reset_overflow", 64'(overflow), 64'd0);
        check_output("reset_drops", 64'(drop_count), 64'd0);
        check_output("reset_num", 64'(tag_bus.tag_trig_num), 64'd0);

        tag_bus.tag_ready = 1'b1;
        fill_type = 2'b01;
        goto_cycle(10);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check_output("t1_valid", 64'(tag_bus.tag_valid), 64'd1);
        check_output("t1_num", 64'(tag_bus.tag_trig_num), 64'd1);
        check_output("t1_ts", 64'(tag_bus.tag_timestamp), 64'd10);
        check_output("t1_fill", 64'(tag_bus.tag_fill_type), 64'd1);
        goto_cycle(15);
        check_output("t1_drained", 64'(tag_bus.tag_valid), 64'd0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check_output("t2_valid", 64'(tag_bus.tag_valid), 64'd1);
        check_output("t2_num", 64'(tag_bus.tag_trig_num), 64'd2);
        check_output("t2_ts", 64'(tag_bus.tag_timestamp), 64'd15);

        $display("[TB] simultaneous clears with trigger");
        goto_cycle(20);
        fill_type = 2'b10;
        reset_trig_num = 1'b1;
        reset_trig_timestamp = 1'b1;
        trigger = 1'b1;
        tick();
        reset_trig_num = 1'b0;
        reset_trig_timestamp = 1'b0;
        trigger = 1'b0;
        check_output("clr_num", 64'(tag_bus.tag_trig_num), 64'd1);
        check_output("clr_ts", 64'(tag_bus.tag_timestamp), 64'd0);
        check_output("clr_fill", 64'(tag_bus.tag_fill_type), 64'd2);
        goto_cycle(25);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check_output("clr_next_num", 64'(tag_bus.tag_trig_num), 64'd2);
        check_output("clr_next_ts", 64'(tag_bus.tag_timestamp), 64'd5);

        $display("[TB] overflow with 17 back-to-back triggers");
        do_reset();
        tag_bus.tag_ready = 1'b0;
        fill_type = 2'b01;
        trigger = 1'b1;
        repeat (17) tick();
        trigger = 1'b0;
        check_output("full_count", 64'(fifo_count), 64'd16);
        check_output("full_overflow", 64'(overflow), 64'd1);
        check_output("full_drops", 64'(drop_count), 64'd1);
        tag_bus.tag_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check_output("drain_num", 64'(tag_bus.tag_trig_num), 64'(i));
            check_output("drain_ts", 64'(tag_bus.tag_timestamp), 64'(i - 1));
            tick();
        end
        check_output("drained_valid", 64'(tag_bus.tag_valid), 64'd0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check_output("gap_num", 64'(tag_bus.tag_trig_num), 64'd18);
        tick();

        $display("[TB] full FIFO with trigger and pop together");
        tag_bus.tag_ready = 1'b0;
        trigger = 1'b1;
        repeat (16) tick();
        trigger = 1'b0;
        check_output("refill_count", 64'(fifo_count), 64'd16);
        trigger = 1'b1;
        tag_bus.tag_ready = 1'b1;
        tick();
        trigger = 1'b0;
        tag_bus.tag_ready = 1'b0;
        check_output("fullpop_count", 64'(fifo_count), 64'd15);
        check_output("fullpop_drops", 64'(drop_count), 64'd2);
        check_output("fullpop_head", 64'(tag_bus.tag_trig_num), 64'd20);
        trigger = 1'b1;
        tag_bus.tag_ready = 1'b1;
        tick();
        trigger = 1'b0;
        tag_bus.tag_ready = 1'b0;
        check_output("pushpop_count", 64'(fifo_count), 64'd15);
        check_output("pushpop_head", 64'(tag_bus.tag_trig_num), 64'd21);
        check_output("pushpop_drops", 64'(drop_count), 64'd2);
        for (int k = 0; k < 20; k++) begin
            tag_bus.tag_ready = 1'b1;
            tick();
            tag_bus.tag_ready = 1'b0;
            check_output("hold_num", 64'(tag_bus.tag_trig_num), 64'(22 + k));
            tick();
            if (fifo_count == 5'd5) break;
        end
        check_output("pre_reset_count", 64'(fifo_count), 64'd5);
        check_output("pre_reset_head", 64'(tag_bus.tag_trig_num), 64'd31);

        $display("[TB] reset with entries queued");
        tag_bus.tag_ready = 1'b1;
        do_reset();
        check_output("mid_reset_valid", 64'(tag_bus.tag_valid), 64'd0);
        check_output("mid_reset_count", 64'(fifo_count), 64'd0);
        check_output("mid_reset_overflow", 64'(overflow), 64'd0);
        check_output("mid_reset_drops", 64'(drop_count), 64'd0);
        check_output("mid_reset_ts_out", 64'(tag_bus.tag_timestamp), 64'd0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check_output("post_reset_num", 64'(tag_bus.tag_trig_num), 64'd1);
        check_output("post_reset_ts", 64'(tag_bus.tag_timestamp), 64'd0);

        $display("[TB] counter wrap on narrow instance");
        do_reset();
        w_fill_type = 2'b11;
        w_trigger = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_output("wrap_num", 64'(w_bus.tag_trig_num), 64'((i + 1) % 16));
            check_output("wrap_num_ts", 64'(w_bus.tag_timestamp), 64'(i));
        end
        w_trigger = 1'b0;
        goto_cycle(63);
        w_trigger = 1'b1;
        tick();
        check_output("ts_top", 64'(w_bus.tag_timestamp), 64'd63);
        check_output("ts_top_num", 64'(w_bus.tag_trig_num), 64'd1);
        tick();
        w_trigger = 1'b0;
        check_output("ts_wrap", 64'(w_bus.tag_timestamp), 64'd0);
        check_output("ts_wrap_num", 64'(w_bus.tag_trig_num), 64'd2);
        check_output("ts_wrap_fill", 64'(w_bus.tag_fill_type), 64'd3);
        check_output("wrap_overflow", 64'(w_overflow), 64'd0);
        check_output("wrap_drops", 64'(w_drop_count), 64'd0);
        tick();
        check_output("wrap_empty", 64'(w_fifo_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
